fft_result_unloader: RTL and testbench
======================================

Name: fft_result_unloader

Overview:
- Reader at the output end of the 32-point FFT core.
- On the core's finish event, captures all N complex Q16.16 results from the parallel result bus into a register bank.
- Streams the captured results one bin per beat over a valid/ready interface to downstream logic (DMA, UART framer, magnitude unit).
- Frees the FFT core to start the next frame as soon as capture completes.

Parameters:
- N, 32, number of FFT bins; power of two, 4..64
- DATA_WIDTH, 32, width of each real/imag word
- INTEGER, 16, integer bits of the fixed-point format (informational, passed through to package)
- FRACTION, 16, fraction bits; INTEGER+FRACTION must equal DATA_WIDTH
- IDX_W, $clog2(N), bin index width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- PU_enable  in  1  processing-unit enable; capture allowed only when high
- finish  in  1  FFT core done flag (level); a new frame is signalled by its rising edge
- fft_real_flat  in  N*DATA_WIDTH  bin k real part at [k*DATA_WIDTH +: DATA_WIDTH]
- fft_imag_flat  in  N*DATA_WIDTH  bin k imag part, same packing
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts beat
- out_real  out  DATA_WIDTH  real part of current beat
- out_imag  out  DATA_WIDTH  imag part of current beat
- out_index  out  IDX_W  bin number of current beat
- out_last  out  1  high on final beat of a frame
- busy  out  1  high while a frame is held or streaming
- overrun  out  1  sticky: a frame arrived while busy and was dropped
- clr_overrun  in  1  single-cycle clear of overrun

Behaviour:
- Reset: state IDLE, finish_d=0, pos=0, bank cleared to 0. Outputs out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0, busy=0, overrun=0.
- Edge detect: fin_rise = finish & ~finish_d, where finish_d is registered every cycle regardless of state.
- IDLE: if fin_rise & PU_enable, load all N real/imag words into the bank, set pos=0, go to STREAM. If fin_rise & ~PU_enable, ignore it and leave overrun unchanged.
- Latency: out_valid goes high the cycle after the fin_rise edge. Bank and pos are registers, so the outputs are glitch-free.
- STREAM:
  - out_valid=1, busy=1.
  - out_real/out_imag come from bank[rd_addr], out_index=rd_addr, out_last=(pos==N-1).
  - Handshake: a beat transfers when out_valid & out_ready. pos increments on transfer only.
  - Outputs are held stable while out_valid & ~out_ready; no beat may change value until accepted.
  - After the last beat (pos==N-1) transfers: return to IDLE, pos wraps to 0, out_valid=0 the next cycle.
- Simultaneous events:
  - Last beat transfers in the same cycle as fin_rise & PU_enable: capture the new frame, stay in STREAM with pos=0, no overrun, no idle bubble.
  - fin_rise & PU_enable while in STREAM, not on the last transfer: drop the frame, set overrun=1, leave the bank untouched.
  - clr_overrun in the same cycle as an overrun set: set wins.
- PU_enable falling mid-stream does not abort; the frame completes.
- Reset mid-stream: immediate return to reset state; the partial frame is discarded and out_valid is 0 the next cycle.
- Bank words are captured verbatim. No scaling, rounding or sign change.

Optional Feature:
- Macro: FFT_UNLOAD_BITREV_EN
- Defined: rd_addr = bit-reverse of pos over IDX_W bits, and out_index reports that bit-reversed bin. This is for use when the core is built in bit-reversed output order and the consumer needs natural bin labels.
- Undefined: rd_addr = pos, natural order. The bit-reverse logic is not instantiated.
- Handshake and timing are identical either way.

Decomposition:
- Package fft_pkg holds: DATA_WIDTH/INTEGER/FRACTION defaults, N_POINTS=32, the unloader state enum typedef (IDLE, STREAM), and the bitrev function.
- One natural sub-module, fft_result_bank: N-entry complex register bank with parallel load and indexed read mux.
- The top keeps the FSM, handshake and flags.

Test Plan:
- Ramp frame (bin k real=k<<16, imag=(-k)<<16), out_ready=1, finish rises at cycle T -> out_valid at T+1; 32 consecutive beats with index 0..31 and real 0x00000000..0x001F0000; out_last only on index 31; busy drops after the last beat.
- Same frame with out_ready toggling 1/0 each cycle -> 32 beats in 63 cycles, each value held while ready=0, no beat lost or duplicated.
- Second finish rise at beat 10 -> overrun=1, streamed values remain frame 1; clr_overrun pulse -> overrun=0.
- Back-to-back: finish rises in the same cycle the beat with index 31 transfers -> next cycle out_valid=1 with index 0 of frame 2 (bin0 real 0x01F00000), overrun stays 0.
- finish rises with PU_enable=0 -> no capture, out_valid stays 0, overrun stays 0.
- Reset asserted at beat 5 -> next cycle all outputs 0; a later finish rise restarts at index 0. With FFT_UNLOAD_BITREV_EN defined, index order is 0,16,8,24,4,...,31.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result path: default fixed-point format,
// unloader state encoding and the bin bit-reverse helper.
package fft_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_INTEGER    = 16;
    localparam int DEFAULT_FRACTION   = 16;
    localparam int N_POINTS           = 32;

    typedef enum logic {
        IDLE,
        STREAM
    } unload_state_t;

    // Reverses the low 'width' bits of value (width <= 8).
    function automatic logic [7:0] bitrev(input logic [7:0] value, input int unsigned width);
        logic [7:0] rev;
        logic [7:0] rest;
        rev  = '0;
        rest = value;
        for (int i = 0; i < 8; i++) begin
            rev  = {rev[6:0], rest[0]};
            rest = {1'b0, rest[7:1]};
        end
        return rev >> (8 - width);
    endfunction

endpackage

// File: rtl/fft_result_bank.sv
// N-entry complex register bank: parallel load of all bins from the flat
// result buses, single indexed read port.
module fft_result_bank
    import fft_pkg::*;
#(
    parameter int N          = N_POINTS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [N*DATA_WIDTH-1:0] real_flat,
    input  logic [N*DATA_WIDTH-1:0] imag_flat,
    input  logic [IDX_W-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_real,
    output logic [DATA_WIDTH-1:0]   rd_imag
);

    logic [DATA_WIDTH-1:0] real_q [N];
    logic [DATA_WIDTH-1:0] imag_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                real_q[k] <= '0;
                imag_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < N; k++) begin
                real_q[k] <= real_flat[k*DATA_WIDTH +: DATA_WIDTH];
                imag_q[k] <= imag_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_real = real_q[rd_addr];
    assign rd_imag = imag_q[rd_addr];

endmodule

// File: rtl/fft_result_unloader.sv
// Captures a finished FFT frame and streams it one bin per valid/ready beat.
// Define FFT_UNLOAD_BITREV_EN to read the bank in bit-reversed bin order.
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int N          = N_POINTS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int INTEGER    = DEFAULT_INTEGER,
    parameter int FRACTION   = DEFAULT_FRACTION,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          PU_enable,
    input  logic                          finish,
    input  logic [N*DATA_WIDTH-1:0]       fft_real_flat,
    input  logic [N*DATA_WIDTH-1:0]       fft_imag_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INTEGER+FRACTION-1:0]   out_real,
    output logic [INTEGER+FRACTION-1:0]   out_imag,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    unload_state_t         state;
    logic                  finish_d;
    logic [IDX_W-1:0]      pos;
    logic [IDX_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] rd_real;
    logic [DATA_WIDTH-1:0] rd_imag;
    logic                  fin_rise;
    logic                  capture_req;
    logic                  at_last;
    logic                  xfer;
    logic                  last_xfer;
    logic                  bank_load;

    assign fin_rise    = finish & ~finish_d;
    assign capture_req = fin_rise & PU_enable;
    assign at_last     = (pos == IDX_W'(N - 1));
    assign xfer        = out_valid & out_ready;
    assign last_xfer   = xfer & at_last;
    // A new frame may only overwrite the bank once the previous one is fully out.
    assign bank_load   = capture_req & ((state == IDLE) | last_xfer);

`ifdef FFT_UNLOAD_BITREV_EN
    assign rd_addr = IDX_W'(bitrev(8'(pos), IDX_W));
`else
    assign rd_addr = pos;
`endif

    fft_result_bank #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .load      (bank_load),
        .real_flat (fft_real_flat),
        .imag_flat (fft_imag_flat),
        .rd_addr   (rd_addr),
        .rd_real   (rd_real),
        .rd_imag   (rd_imag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            finish_d <= 1'b0;
            pos      <= '0;
            overrun  <= 1'b0;
        end else begin
            finish_d <= finish;
            if (clr_overrun) begin
                overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (capture_req) begin
                        state <= STREAM;
                        pos   <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        pos <= pos + IDX_W'(1);
                    end
                    // pos wraps to 0 on the last beat since N is a power of two.
                    if (last_xfer) begin
                        if (!capture_req) begin
                            state <= IDLE;
                        end
                    end else if (capture_req) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_last  = (state == STREAM) & at_last;
    assign out_index = rd_addr;
    assign out_real  = rd_real;
    assign out_imag  = rd_imag;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Self-checking bench for fft_result_unloader: vector table, directed corner
// sequences and a randomized run against a frame/beat-level reference model.
module tb_fft_result_unloader;

    localparam int N     = 32;
    localparam int DW    = 32;
    localparam int IDX_W = 5;

    logic            clk;
    logic            reset;
    logic            PU_enable;
    logic            finish;
    logic [N*DW-1:0] fft_real_flat;
    logic [N*DW-1:0] fft_imag_flat;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_real;
    logic [DW-1:0]   out_imag;
    logic [IDX_W-1:0] out_index;
    logic            out_last;
    logic            busy;
    logic            overrun;
    logic            clr_overrun;

    int tests_run;
    int tests_failed;

    // Reference model state: whole frames and beat counts, not FSM states.
    bit            m_active;
    int            m_beat;
    bit            m_overrun;
    bit            m_fin_prev;
    logic [DW-1:0] m_real [N];
    logic [DW-1:0] m_imag [N];

    fft_result_unloader #(
        .N          (N),
        .DATA_WIDTH (DW),
        .INTEGER    (16),
        .FRACTION   (16),
        .IDX_W      (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PU_enable     (PU_enable),
        .finish        (finish),
        .fft_real_flat (fft_real_flat),
        .fft_imag_flat (fft_imag_flat),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .out_index     (out_index),
        .out_last      (out_last),
        .busy          (busy),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bin label of the n-th beat of a frame.
    function automatic int order(input int beat);
`ifdef FFT_UNLOAD_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < IDX_W; b++) begin
            if (((beat >> b) & 1) == 1) r += (1 << (IDX_W - 1 - b));
        end
        return r;
`else
        return beat;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0: begin
                    fft_real_flat[k*DW +: DW] = 32'(k) << 16;
                    fft_imag_flat[k*DW +: DW] = 32'(-k) << 16;
                end
                1: begin
                    fft_real_flat[k*DW +: DW] = 32'(16'h01F0 + k) << 16;
                    fft_imag_flat[k*DW +: DW] = 32'(k);
                end
                default: begin
                    fft_real_flat[k*DW +: DW] = $urandom;
                    fft_imag_flat[k*DW +: DW] = $urandom;
                end
            endcase
        end
    endtask

    task automatic model_step();
        bit rise;
        bit xfer;
        bit done;
        if (reset) begin
            m_active   = 0;
            m_beat     = 0;
            m_overrun  = 0;
            m_fin_prev = 0;
            for (int k = 0; k < N; k++) begin
                m_real[k] = '0;
                m_imag[k] = '0;
            end
            return;
        end
        rise       = finish && !m_fin_prev;
        m_fin_prev = finish;
        xfer       = m_active && out_ready;
        done       = xfer && (m_beat == N - 1);
        if (xfer) m_beat++;
        if (clr_overrun) m_overrun = 0;
        if (done) begin
            m_active = 0;
            m_beat   = 0;
        end
        if (rise && PU_enable) begin
            if (!m_active) begin
                for (int k = 0; k < N; k++) begin
                    m_real[k] = fft_real_flat[k*DW +: DW];
                    m_imag[k] = fft_imag_flat[k*DW +: DW];
                end
                m_active = 1;
                m_beat   = 0;
            end else begin
                m_overrun = 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fin, input logic pu,
                                 input logic rdy, input logic clr);
        reset       = rst;
        finish      = fin;
        PU_enable   = pu;
        out_ready   = rdy;
        clr_overrun = clr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_active));
        check({tag, ".busy"}, 32'(busy), 32'(m_active));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
        if (m_active) begin
            check({tag, ".index"}, 32'(out_index), 32'(order(m_beat)));
            check({tag, ".real"}, out_real, m_real[order(m_beat)]);
            check({tag, ".imag"}, out_imag, m_imag[order(m_beat)]);
            check({tag, ".last"}, 32'(out_last), 32'(m_beat == N - 1));
        end else begin
            check({tag, ".last_idle"}, 32'(out_last), 32'd0);
        end
    endtask

    typedef struct {
        logic rst, fin, pu, rdy, clr;
        logic exp_valid;
        int   exp_beat;
        logic exp_ovr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int beats;
        int cycles;
        tests_run    = 0;
        tests_failed = 0;
        reset = 1; finish = 0; PU_enable = 0; out_ready = 0; clr_overrun = 0;
        fft_real_flat = '0;
        fft_imag_flat = '0;
        load_frame(0);

        // Table: ignored edge, hold under backpressure, overrun set/clear, reset.
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 1, 2, 0};
        tbl[8]  = '{0, 1, 1, 0, 0, 1, 2, 1};
        tbl[9]  = '{0, 1, 1, 0, 1, 1, 2, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 1, 2, 0};
        tbl[11] = '{0, 1, 1, 0, 1, 1, 2, 1};
        tbl[12] = '{1, 0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].fin, tbl[i].pu, tbl[i].rdy, tbl[i].clr);
            check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d.overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
            check($sformatf("tbl%0d.last", i), 32'(out_last), 32'd0);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d.index", i), 32'(out_index), 32'(order(tbl[i].exp_beat)));
                check($sformatf("tbl%0d.real", i), out_real, 32'(order(tbl[i].exp_beat)) << 16);
                check($sformatf("tbl%0d.imag", i), out_imag, 32'(-order(tbl[i].exp_beat)) << 16);
            end else if (tbl[i].rst) begin
                check($sformatf("tbl%0d.rst_index", i), 32'(out_index), 32'd0);
                check($sformatf("tbl%0d.rst_real", i), out_real, 32'd0);
                check($sformatf("tbl%0d.rst_imag", i), out_imag, 32'd0);
            end
        end

        // Ramp frame at full rate: valid one cycle after the edge, 32 beats.
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        check("ramp.first_valid", 32'(out_valid), 32'd1);
        for (int b = 0; b < N; b++) begin
            checkOutput("ramp");
            check("ramp.index", 32'(out_index), 32'(order(b)));
            check("ramp.real", out_real, 32'(order(b)) << 16);
            check("ramp.last", 32'(out_last), 32'(b == N - 1));
            applyStimulus(0, 1, 1, 1, 0);
        end
        check("ramp.valid_after", 32'(out_valid), 32'd0);
        check("ramp.busy_after", 32'(busy), 32'd0);

        // Alternating ready: 32 distinct beats in 63 cycles.
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        beats  = 0;
        cycles = 0;
        while (out_valid && cycles < 100) begin
            checkOutput("toggle");
            if ((cycles % 2) == 0) begin
                check("toggle.seq_index", 32'(out_index), 32'(order(beats)));
                beats++;
            end
            applyStimulus(0, 0, 1, (cycles % 2) == 0, 0);
            cycles++;
        end
        check("toggle.beats", 32'(beats), 32'(N));
        check("toggle.cycles", 32'(cycles), 32'(2 * N - 1));

        // Back-to-back: new frame edge on the final transfer, no bubble.
        applyStimulus(0, 1, 1, 1, 0);
        for (int b = 0; b < N; b++) begin
            checkOutput("b2b");
            if (b == N - 1) begin
                load_frame(1);
                applyStimulus(0, 1, 1, 1, 0);
            end else begin
                applyStimulus(0, 0, 1, 1, 0);
            end
        end
        check("b2b.valid", 32'(out_valid), 32'd1);
        check("b2b.index", 32'(out_index), 32'(order(0)));
        check("b2b.real", out_real, 32'h01F0_0000);
        check("b2b.overrun", 32'(overrun), 32'd0);
        for (int b = 0; b < N; b++) begin
            checkOutput("b2b2");
            applyStimulus(0, 0, 1, 1, 0);
        end
        check("b2b2.done", 32'(out_valid), 32'd0);

        // Reset at beat 5, then a fresh capture restarts at beat 0.
        load_frame(0);
        applyStimulus(0, 1, 1, 1, 0);
        for (int b = 0; b < 5; b++) applyStimulus(0, 0, 1, 1, 0);
        check("rst.mid_index", 32'(out_index), 32'(order(5)));
        applyStimulus(1, 0, 1, 1, 0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.last", 32'(out_last), 32'd0);
        check("rst.index", 32'(out_index), 32'd0);
        check("rst.real", out_real, 32'd0);
        check("rst.imag", out_imag, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        check("rst.restart_index", 32'(out_index), 32'(order(0)));
        checkOutput("rst.restart");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) load_frame(2);
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) < 3 ? ~finish : finish,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 19) == 0);
            checkOutput("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
